imm_encoder: RTL and testbench
==============================

// Module: imm_encoder
// PURPOSE
// - Inverse of the pipeline's immediate extender: packs a 32-bit immediate into the immediate fields of an
//   RV32I instruction word (I/S/B/J formats) over a base word carrying opcode/funct/register fields.
// - Sits in the debug/boot instruction-injection path, between the command source and the
//   instruction-memory writer. Valid/ready on both sides, one output register stage.
// PARAMETERS
// - CNT_W   16   width of the encoded-word and error counters (both saturate at 2**CNT_W-1)
// PORTS
// - clk        in   1      clock, all state updates on rising edge
// - resetn     in   1      reset, synchronous, active-low
// - in_valid   in   1      request valid
// - in_ready   out  1      block can accept a request this cycle
// - in_base    in   32     base instruction; bits in the selected immediate fields are ignored
// - in_imm     in   32     immediate value (two's complement)
// - in_ImmSrc  in   2      00=I, 01=S, 10=B, 11=J (same encoding as the extender)
// - out_valid  out  1      out_instr valid
// - out_ready  in   1      downstream accepts
// - out_instr  out  32     packed instruction
// - out_err    out  1      immediate not representable in the selected format (qualified by out_valid)
// - enc_count  out  CNT_W  words delivered (out_valid & out_ready), saturating
// - err_count  out  CNT_W  delivered words with out_err=1, saturating
// BEHAVIOUR
// - Reset (resetn=0 at posedge): out_valid=0, out_instr=0, out_err=0, enc_count=0, err_count=0.
//   Reset wins over any handshake in the same cycle; an in-flight word is dropped.
// - in_ready = ~out_valid | out_ready (combinational); in_ready=0 while resetn=0.
// - Accept on in_valid & in_ready: next cycle out_valid=1 with out_instr/out_err. Latency 1, 1 word/cycle.
// - Hold: out_valid & ~out_ready -> out_instr/out_err stable, no new accept.
// - Simultaneous drain and accept -> register reloads; out_valid stays 1 (no bubble).
// - Drain without accept -> out_valid=0 next cycle; out_instr holds its last value.
// - Packing (all bits not listed are copied from in_base):
//   I: [31:20]=imm[11:0]
//   S: [31:25]=imm[11:5], [11:7]=imm[4:0]
//   B: [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1]
//   J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]
// - Representability (used by the optional check):
//   I/S: imm[31:11] all equal
//   B:   imm[31:12] all equal and imm[0]=0
//   J:   imm[31:20] all equal and imm[0]=0
// - Unrepresentable imm is still packed (truncated per the table above); only out_err flags it.
// - Counters increment only on an output handshake; at saturation they hold the max value.
// CONFIGURATION
// - IMM_RANGE_CHECK_EN defined: out_err computed per the representability rules; err_count counts.
// - Not defined: range logic removed; out_err and err_count tied to 0. Packing is unchanged.
// TESTING
// - I: base=0x00000093, imm=0xFFFFFFFF, src=00 -> out_instr=0xFFF00093, err=0, one cycle after accept.
// - S: base=0x0020A023, imm=0x00000008, src=01 -> out_instr=0x0020A423, err=0.
// - B: base=0x00000063, imm=0xFFFFFFFC, src=10 -> 0xFE000EE3; then imm=0x00001001 -> err=1 (EN) / 0 (no EN).
// - J: base=0x0000006F, imm=0x00000008, src=11 -> 0x0080006F; then imm=0x00100000 -> err=1 with EN.
// - Backpressure: out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 and out_instr stable;
//   then out_ready=1 -> back-to-back words, no bubble, enc_count +1 per cycle.
// - Reset mid-stream: resetn=0 while out_valid=1 -> next cycle out_valid=0, counters=0, in_ready=0 during reset.

Source files
------------

// File: rtl/imm_encoder.sv
// imm_encoder: packs a 32-bit immediate into RV32I I/S/B/J fields; `define IMM_RANGE_CHECK_EN adds out_err/err_count
module imm_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_base,
  input  logic [31:0]      in_imm,
  input  logic [1:0]       in_ImmSrc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);
  logic             valid_q;
  logic [31:0]      instr_q, instr_d;
  logic [CNT_W-1:0] enc_q, enc_d;
  logic             acc, drn;
  logic             unused_base;
  // every format places immediate bits in [31:25], so those base bits are never copied
  assign unused_base = ^in_base[31:25];
  assign in_ready = resetn & (~valid_q | out_ready);
  assign acc = in_valid & in_ready;
  assign drn = valid_q & out_ready;
  always_comb begin
    instr_d = in_ImmSrc == 2'b00 ? {in_imm[11:0], in_base[19:0]} :
              in_ImmSrc == 2'b01 ? {in_imm[11:5], in_base[24:12], in_imm[4:0], in_base[6:0]} :
              in_ImmSrc == 2'b10 ? {in_imm[12], in_imm[10:5], in_base[24:12], in_imm[4:1], in_imm[11], in_base[6:0]} :
                                   {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_base[11:0]};
    enc_d = drn & ~&enc_q ? enc_q + CNT_W'(1) : enc_q;
  end
  always_ff @(posedge clk)
    if (!resetn) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      enc_q   <= '0;
    end else begin
      valid_q <= acc | (valid_q & ~out_ready);
      if (acc) instr_q <= instr_d;
      enc_q <= enc_d;
    end
  assign out_valid = valid_q;
  assign out_instr = instr_q;
  assign enc_count = enc_q;
`ifdef IMM_RANGE_CHECK_EN
  logic             err_q, err_d;
  logic [CNT_W-1:0] errc_q, errc_d;
  always_comb begin
    err_d = ~in_ImmSrc[1] ? ~(&in_imm[31:11] | ~|in_imm[31:11]) :
            ~in_ImmSrc[0] ? ~(&in_imm[31:12] | ~|in_imm[31:12]) | in_imm[0] :
                            ~(&in_imm[31:20] | ~|in_imm[31:20]) | in_imm[0];
    errc_d = drn & err_q & ~&errc_q ? errc_q + CNT_W'(1) : errc_q;
  end
  always_ff @(posedge clk)
    if (!resetn) begin
      err_q  <= 1'b0;
      errc_q <= '0;
    end else begin
      if (acc) err_q <= err_d;
      errc_q <= errc_d;
    end
  assign out_err   = err_q;
  assign err_count = errc_q;
`else
  logic unused_imm;
  assign unused_imm = ^in_imm[31:21];
  assign out_err   = 1'b0;
  assign err_count = '0;
`endif
endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: randomized and directed checks of imm_encoder against a bit-map reference model
module tb_imm_encoder;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] MAXC = '1;
`ifdef IMM_RANGE_CHECK_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif
  logic             clk = 1'b0;
  logic             resetn, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [31:0]      in_base, in_imm, out_instr;
  logic [1:0]       in_ImmSrc;
  logic [CNT_W-1:0] enc_count, err_count;
  int checks = 0;
  int errors = 0;
  logic             m_valid, m_err;
  logic [31:0]      m_instr;
  logic [CNT_W-1:0] m_enc, m_errc;

  imm_encoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_base(in_base), .in_imm(in_imm), .in_ImmSrc(in_ImmSrc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_err(out_err), .enc_count(enc_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // immediate bit that lands on instruction bit i, or -1 when the base bit is kept
  function automatic int imm_bit(input logic [1:0] s, input int i);
    case (s)
      2'd0: return i >= 20 ? i - 20 : -1;
      2'd1: return i >= 25 ? i - 20 : (i >= 7 && i <= 11) ? i - 7 : -1;
      2'd2: return i == 31 ? 12 : i >= 25 ? i - 20 : (i >= 8 && i <= 11) ? i - 7 : i == 7 ? 11 : -1;
      default: return i == 31 ? 20 : i >= 21 ? i - 20 : i == 20 ? 11 : i >= 12 ? i : -1;
    endcase
  endfunction

  function automatic logic [31:0] pack(input logic [31:0] b, input logic [31:0] imm, input logic [1:0] s);
    logic [31:0] r;
    int k;
    r = b;
    for (int i = 0; i < 32; i++) begin
      k = imm_bit(s, i);
      if (k >= 0) r[i] = imm[k];
    end
    return r;
  endfunction

  function automatic logic unrep(input logic [31:0] imm, input logic [1:0] s);
    longint v, lim;
    int w;
    v = longint'($signed(imm));
    w = s[1] == 1'b0 ? 12 : s == 2'd2 ? 13 : 21;
    lim = longint'(1) << (w - 1);
    return EN && (v < -lim || v >= lim || (s[1] && imm[0]));
  endfunction

  function automatic logic [31:0] rand_imm();
    logic [31:0] b [10];
    logic [31:0] v;
    int w;
    b = '{32'd2047, 32'd2048, 32'hFFFFF800, 32'hFFFFF7FF, 32'd4094, 32'd4096,
          32'hFFFFF000, 32'h000FFFFE, 32'h00100000, 32'hFFF00000};
    case ($urandom_range(0, 2))
      0: return $urandom;
      1: return b[$urandom_range(0, 9)];
      default: begin
        w = $urandom_range(10, 21);
        v = $urandom;
        v = $signed(v << (32 - w)) >>> (32 - w);
        if ($urandom_range(0, 1) == 1) v[0] = 1'b0;
        return v;
      end
    endcase
  endfunction

  task automatic rand_inputs();
    in_base = $urandom;
    in_imm = rand_imm();
    in_ImmSrc = 2'($urandom_range(0, 3));
  endtask

  // advances one clock and updates the reference model from the inputs seen at that edge
  task automatic tick();
    logic acc, drn;
    acc = in_valid && resetn && (!m_valid || out_ready);
    drn = m_valid && out_ready;
    @(posedge clk);
    if (!resetn) begin
      m_valid = 1'b0; m_instr = '0; m_err = 1'b0; m_enc = '0; m_errc = '0;
    end else begin
      if (drn && m_enc != MAXC) m_enc = m_enc + 1'b1;
      if (drn && m_err && m_errc != MAXC) m_errc = m_errc + 1'b1;
      if (acc) begin
        m_valid = 1'b1;
        m_instr = pack(in_base, in_imm, in_ImmSrc);
        m_err = unrep(in_imm, in_ImmSrc);
      end else if (drn) m_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    rand_inputs();
    tick();
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++;
    if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", out_instr); end
    checks++;
    if (out_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", out_err); end
    checks++;
    if (enc_count !== '0 || err_count !== '0) begin
      errors++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", enc_count, err_count);
    end
    resetn = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] vb [8], vi [8], vx [8];
    logic [1:0]  vs [8];
    logic        ve [8];
    vb = '{32'h93, 32'h93, 32'h93, 32'h0020A023, 32'h63, 32'h63, 32'h6F, 32'h6F};
    vi = '{32'hFFFFFFFF, 32'h800, 32'hFFFFF800, 32'h8, 32'hFFFFFFFC, 32'h1001, 32'h8, 32'h00100000};
    vs = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
    vx = '{32'hFFF00093, 32'h80000093, 32'h80000093, 32'h0020A423,
           32'hFE000EE3, 32'h80000063, 32'h0080006F, 32'h8000006F};
    ve = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_base = vb[i]; in_imm = vi[i]; in_ImmSrc = vs[i];
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL dir_in_ready[%0d]: got %b expected 1", i, in_ready); end
      tick();
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL dir_valid[%0d]: got %b expected 1", i, out_valid); end
      checks++;
      if (out_instr !== vx[i]) begin errors++; $display("FAIL dir_instr[%0d]: got %h expected %h", i, out_instr, vx[i]); end
      checks++;
      if (out_err !== (ve[i] & EN)) begin
        errors++; $display("FAIL dir_err[%0d]: got %b expected %b", i, out_err, ve[i] & EN);
      end
      checks++;
      if (enc_count !== CNT_W'(i)) begin errors++; $display("FAIL dir_enc[%0d]: got %0d expected %0d", i, enc_count, i); end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b expected 0", out_valid); end
    checks++;
    if (out_instr !== 32'h8000006F) begin errors++; $display("FAIL drain_hold: got %h expected 8000006f", out_instr); end
    checks++;
    if (enc_count !== CNT_W'(8)) begin errors++; $display("FAIL drain_enc: got %0d expected 8", enc_count); end
    checks++;
    if (err_count !== CNT_W'(EN ? 3 : 0)) begin
      errors++; $display("FAIL drain_errc: got %0d expected %0d", err_count, EN ? 3 : 0);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    logic [CNT_W-1:0] prev;
    do_reset();
    in_valid = 1'b1; out_ready = 1'b0;
    rand_inputs();
    tick();
    held = m_instr;
    checks++;
    if (out_instr !== held) begin errors++; $display("FAIL bp_first: got %h expected %h", out_instr, held); end
    for (int i = 0; i < 5; i++) begin
      rand_inputs();
      #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, in_ready); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_instr !== held) begin
        errors++; $display("FAIL bp_hold[%0d]: got %b/%h expected 1/%h", i, out_valid, out_instr, held);
      end
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rand_inputs();
      prev = m_enc;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d]: got %b expected 1", i, in_ready); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_instr !== m_instr) begin
        errors++; $display("FAIL b2b_word[%0d]: got %b/%h expected 1/%h", i, out_valid, out_instr, m_instr);
      end
      checks++;
      if (enc_count !== prev + 1'b1) begin
        errors++; $display("FAIL b2b_enc[%0d]: got %0d expected %0d", i, enc_count, prev + 1'b1);
      end
    end
  endtask

  task automatic test_reset_midstream();
    resetn = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    rand_inputs();
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_in_ready: got %b expected 0", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_err !== 1'b0) begin
      errors++; $display("FAIL mid_out: got %b/%h/%b expected 0/0/0", out_valid, out_instr, out_err);
    end
    checks++;
    if (enc_count !== '0 || err_count !== '0) begin
      errors++; $display("FAIL mid_counts: got %0d/%0d expected 0/0", enc_count, err_count);
    end
    resetn = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      resetn = $urandom_range(0, 99) != 0;
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 9) < 7;
      rand_inputs();
      #1;
      checks++;
      if (in_ready !== (resetn && (!m_valid || out_ready))) begin
        errors++; $display("FAIL rnd_in_ready[%0d]: got %b expected %b", i, in_ready, resetn && (!m_valid || out_ready));
      end
      tick();
      checks++;
      if (out_valid !== m_valid) begin errors++; $display("FAIL rnd_valid[%0d]: got %b expected %b", i, out_valid, m_valid); end
      checks++;
      if (out_instr !== m_instr) begin errors++; $display("FAIL rnd_instr[%0d]: got %h expected %h", i, out_instr, m_instr); end
      checks++;
      if (out_err !== m_err) begin errors++; $display("FAIL rnd_err[%0d]: got %b expected %b", i, out_err, m_err); end
      checks++;
      if (enc_count !== m_enc) begin errors++; $display("FAIL rnd_enc[%0d]: got %0d expected %0d", i, enc_count, m_enc); end
      checks++;
      if (err_count !== m_errc) begin errors++; $display("FAIL rnd_errc[%0d]: got %0d expected %0d", i, err_count, m_errc); end
    end
  endtask

  initial begin
    resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_base = '0; in_imm = '0; in_ImmSrc = '0;
    m_valid = 1'b0; m_instr = '0; m_err = 1'b0; m_enc = '0; m_errc = '0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midstream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
